// File: rtl/mbe_mult_pkg.sv
// Shared types and helpers for the streaming radix-4 Booth multiplier.
package mbe_mult_pkg;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_t;

    // Window is {b[2i+1], b[2i], b[2i-1]}; the -0 digit encodes as plain zero.
    function automatic booth_t booth_encode(input logic [2:0] w);
        booth_t d;
        d = '0;
        unique case (w)
            3'b001, 3'b010: d = '{neg: 1'b0, one: 1'b1, two: 1'b0};
            3'b011:         d = '{neg: 1'b0, one: 1'b0, two: 1'b1};
            3'b100:         d = '{neg: 1'b1, one: 1'b0, two: 1'b1};
            3'b101, 3'b110: d = '{neg: 1'b1, one: 1'b1, two: 1'b0};
            default:        d = '0;
        endcase
        return d;
    endfunction

    function automatic int ndig(input int w);
        return w / 2 + 1;
    endfunction

endpackage

// File: rtl/mbe_mult_stream_if.sv
// Operand/result streaming bundle for mbe_mult_stream.
interface mbe_mult_stream_if #(
    parameter int WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_data;

    modport master (
        output in_valid, in_a, in_b, in_signed, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/mbe_pp_core.sv
// Combinational radix-4 Booth encoder, partial-product array and adder.
module mbe_pp_core
    import mbe_mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sgn,
    output logic [2*WIDTH-1:0] p
);
    localparam int EW = WIDTH + 2;
    localparam int NW = EW + 1;
    localparam int PW = 2 * WIDTH;
    localparam int ND = ndig(WIDTH);

    // Each row has its sign bit inverted (adds 2^(NW-1)); this folds the
    // matching negative weights into one constant seed.
    function automatic logic [PW-1:0] bias();
        logic [PW-1:0] k;
        k = '0;
        for (int i = 0; i < ND; i++)
            k = k - (PW'(1) << (NW - 1 + 2 * i));
        return k;
    endfunction

    localparam logic [PW-1:0] KC = bias();

    logic [EW-1:0] ax;
    logic [EW:0]   bw;
    booth_t        dg;
    logic [NW-1:0] sel;
    logic [NW-1:0] pp;
    logic [PW-1:0] sum;

    assign ax = {{2{sgn & a[WIDTH-1]}}, a};
    assign bw = {{2{sgn & b[WIDTH-1]}}, b, 1'b0};

    always_comb begin
        sum = KC;
        dg  = '0;
        sel = '0;
        pp  = '0;
        for (int i = 0; i < ND; i++) begin
            dg  = booth_encode(bw[2*i +: 3]);
            sel = dg.two ? {ax, 1'b0}
                : dg.one ? {ax[EW-1], ax}
                : '0;
            pp  = sel ^ {NW{dg.neg}};
            sum = sum
                + (PW'({~pp[NW-1], pp[NW-2:0]}) << (2 * i))
                + (PW'(dg.neg) << (2 * i));
        end
        p = sum;
    end

endmodule

// File: rtl/mbe_mult_stream.sv
// Pipelined Booth multiplier with credit-based output buffer.
// Define MBE_MULT_CHECK_EN to enable the shadow-model result checker.
module mbe_mult_stream
    import mbe_mult_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int PIPE       = 2,
    parameter int OBUF_DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    mbe_mult_stream_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int AW = $clog2(OBUF_DEPTH);
    localparam int CW = $clog2(OBUF_DEPTH + 1);
    localparam int PD = (PIPE > 0) ? PIPE : 1;
    localparam logic [CW:0] LIM = (CW + 1)'(OBUF_DEPTH);

    state_t           state;
    logic             acc;
    logic             pop;
    logic             wr_v;
    logic [PW-1:0]    wr_d;
    logic [PW-1:0]    prod;
    logic             s0_v;
    logic             s0_sgn;
    logic [WIDTH-1:0] s0_a;
    logic [WIDTH-1:0] s0_b;
    logic [CW-1:0]    occ;
    logic [CW-1:0]    cnt;
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [PW-1:0]    mem [OBUF_DEPTH];

    // Credits count everything between accept and pop, so a write
    // always finds a free slot and the pipeline never has to stall.
    assign bus.in_ready  = (state == RUN)
                         && (({1'b0, occ} + {1'b0, cnt}) < LIM);
    assign bus.out_valid = (cnt != '0);
    assign bus.out_data  = bus.out_valid ? mem[rp] : '0;

    assign acc = bus.in_valid & bus.in_ready;
    assign pop = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
        end else begin
            unique case (state)
                INIT:    state <= RUN;
                RUN:     state <= RUN;
                default: state <= INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_v   <= 1'b0;
            s0_sgn <= 1'b0;
            s0_a   <= '0;
            s0_b   <= '0;
        end else begin
            s0_v <= acc;
            if (acc) begin
                s0_sgn <= bus.in_signed;
                s0_a   <= bus.in_a;
                s0_b   <= bus.in_b;
            end
        end
    end

    mbe_pp_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a   (s0_a),
        .b   (s0_b),
        .sgn (s0_sgn),
        .p   (prod)
    );

    if (PIPE == 0) begin : g_nopipe
        assign wr_v = s0_v;
        assign wr_d = prod;
    end else begin : g_pipe
        logic [PD-1:0] pv;
        logic [PW-1:0] pd [PD];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pv <= '0;
            end else begin
                pv[0] <= s0_v;
                for (int k = 1; k < PD; k++)
                    pv[k] <= pv[k-1];
            end
        end

        always_ff @(posedge clk) begin
            pd[0] <= prod;
            for (int k = 1; k < PD; k++)
                pd[k] <= pd[k-1];
        end

        assign wr_v = pv[PD-1];
        assign wr_d = pd[PD-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ <= '0;
            cnt <= '0;
            wp  <= '0;
            rp  <= '0;
        end else begin
            occ <= occ + CW'(acc) - CW'(wr_v);
            cnt <= cnt + CW'(wr_v) - CW'(pop);
            if (wr_v)
                wp <= wp + AW'(1);
            if (pop)
                rp <= rp + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_v)
            mem[wp] <= wr_d;
    end

`ifdef MBE_MULT_CHECK_EN
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sgn;
    } shadow_t;

    shadow_t       shq[$];
    shadow_t       sh;
    logic [PW-1:0] ref_p;
    logic [PW-1:0] held_d;
    logic          held;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            shq.delete();
            held   <= 1'b0;
            held_d <= '0;
        end else begin
            if (held)
                assert (bus.out_valid && bus.out_data == held_d)
                else $error("mbe_mult_stream: output moved while stalled");
            if (wr_v && !pop)
                assert ({1'b0, cnt} < LIM)
                else $error("mbe_mult_stream: buffer overflow");
            if (pop)
                assert (cnt != '0)
                else $error("mbe_mult_stream: buffer underflow");
            if (acc)
                shq.push_back('{bus.in_a, bus.in_b, bus.in_signed});
            if (pop) begin
                assert (shq.size() != 0)
                else $error("mbe_mult_stream: result without operands");
                if (shq.size() != 0) begin
                    sh = shq.pop_front();
                    if (sh.sgn)
                        ref_p = $signed({{WIDTH{sh.a[WIDTH-1]}}, sh.a})
                              * $signed({{WIDTH{sh.b[WIDTH-1]}}, sh.b});
                    else
                        ref_p = {{WIDTH{1'b0}}, sh.a}
                              * {{WIDTH{1'b0}}, sh.b};
                    assert (bus.out_data == ref_p)
                    else $error("mbe_mult_stream: product %h != %h",
                                bus.out_data, ref_p);
                end
            end
            held   <= bus.out_valid & ~bus.out_ready;
            held_d <= bus.out_data;
        end
    end
`endif

endmodule
